// File: rtl/result_frame_sender_pkg.sv
// Shared definitions for the result frame sender: frame marker bytes,
// the sender state encoding and the packed status bundle.
// Optional feature macro: RESULT_FRAME_CHECKSUM_EN (adds the SEND_CHK state).
package result_frame_sender_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hFE;
    localparam logic [7:0] FRAME_END = 8'hEF;
    localparam int         MAX_N     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_SEND_HDR,
        ST_SEND_LEN,
        ST_SEND_DATA,
`ifdef RESULT_FRAME_CHECKSUM_EN
        ST_SEND_CHK,
`endif
        ST_SEND_END
    } SENDER_STATE_T;

    typedef struct packed {
        logic busy;
        logic done;
        logic overflow;
    } SENDER_STATUS_T;

    // A frame may only be opened for a matrix size of 1..MAX_N.
    function automatic logic n_is_legal(input logic [3:0] n);
        return (n != 4'd0) && (n <= 4'(MAX_N));
    endfunction

endpackage

// File: rtl/result_frame_sender_buffer.sv
// Result buffer: DEPTH x DATA_W synchronous FIFO with sync clear.
// rd_data is the head entry, rd_data_nxt the entry behind it, so the sender
// can stage the first byte of the following word in the same cycle it pops.
// Pushes into a full buffer and pops from an empty one are ignored.
module result_buffer
    import result_frame_sender_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] rd_data_nxt,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_ptr_inc;
    logic              do_push;
    logic              do_pop;

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;
    assign rd_ptr_inc  = rd_ptr + 1'b1;
    assign rd_data     = mem[rd_ptr];
    assign rd_data_nxt = mem[rd_ptr_inc];

    // Storage array; contents are don't-care whenever count says empty.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap modulo DEPTH; count tracks occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/result_frame_sender.sv
// Collects N processor results, then sends them as a byte frame:
//   FE, N, data bytes (MSB first per word), [checksum], EF
// over a valid/ready byte interface. All outputs are registered; the byte
// presented next is computed one step ahead from the next state.
// Optional feature macro: RESULT_FRAME_CHECKSUM_EN -- adds SEND_CHK, which
// emits the XOR of the LEN byte and every data byte.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | waiting for the first push of a frame; latches N
// COLLECT      | capturing results until n_lat are buffered
// SEND_HDR     | presenting 0xFE
// SEND_LEN     | presenting {4'b0, n_lat}
// SEND_DATA    | presenting buffered words, MSB byte first
// SEND_CHK     | presenting XOR checksum (checksum build only)
// SEND_END     | presenting 0xEF; done pulses after it transfers
module result_frame_sender
    import result_frame_sender_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                push_result,
    input  logic [1:0]          processor_number,
    input  logic [4*DATA_W-1:0] proc_results,
    input  logic [3:0]          N,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int   BPW       = DATA_W / 8;
    localparam int   CW        = $clog2(DEPTH + 1);
    localparam logic LAST_BYTE = (BPW == 2);

    SENDER_STATE_T  state, state_nxt;
    SENDER_STATUS_T status_q;
    logic [3:0]     n_lat, n_nxt;
    logic           byte_idx, byte_nxt;
    logic [7:0]     tx_data_q, tx_data_nxt;
    logic           tx_valid_q, tx_valid_nxt;
    logic           done_nxt;
    logic           ov_set;
    logic           xfer;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W-1:0] lane_data;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] rd_data_nxt;

`ifdef RESULT_FRAME_CHECKSUM_EN
    logic [7:0] chk_q, chk_nxt;
`endif

    assign lane_data = proc_results[int'(processor_number) * DATA_W +: DATA_W];
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = status_q.busy;
    assign done      = status_q.done;
    assign overflow  = status_q.overflow;

    // Byte idx of a word, counted from the most significant byte.
    function automatic logic [7:0] word_byte(input logic [DATA_W-1:0] w,
                                             input logic              idx);
        logic [DATA_W-1:0] sh;
        sh = w >> (8 * (BPW - 1 - int'(idx)));
        return sh[7:0];
    endfunction

    result_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buffer (
        .clk         (clk),
        .reset       (reset),
        .clr         (clr),
        .push        (fifo_push),
        .pop         (fifo_pop),
        .wr_data     (lane_data),
        .rd_data     (rd_data),
        .rd_data_nxt (rd_data_nxt),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count)
    );

    // Next state, next presented byte, buffer control and drop detection.
    always_comb begin
        state_nxt    = state;
        n_nxt        = n_lat;
        byte_nxt     = byte_idx;
        tx_data_nxt  = tx_data_q;
        tx_valid_nxt = tx_valid_q;
        fifo_push    = 1'b0;
        fifo_pop     = 1'b0;
        ov_set       = 1'b0;
        done_nxt     = 1'b0;
        xfer         = tx_valid_q && tx_ready;
`ifdef RESULT_FRAME_CHECKSUM_EN
        chk_nxt      = chk_q;
`endif

        case (state)
            ST_IDLE: begin
                if (push_result) begin
                    if (n_is_legal(N)) begin
                        n_nxt     = N;
                        fifo_push = 1'b1;
                        if (N == 4'd1) begin
                            state_nxt    = ST_SEND_HDR;
                            tx_valid_nxt = 1'b1;
                            tx_data_nxt  = FRAME_HDR;
                        end else begin
                            state_nxt = ST_COLLECT;
                        end
                    end else begin
                        ov_set = 1'b1;
                    end
                end
            end

            ST_COLLECT: begin
                if (push_result) begin
                    if (fifo_full) begin
                        ov_set = 1'b1;
                    end else begin
                        fifo_push = 1'b1;
                        if (CW'(fifo_count + 1'b1) == CW'(n_lat)) begin
                            state_nxt    = ST_SEND_HDR;
                            tx_valid_nxt = 1'b1;
                            tx_data_nxt  = FRAME_HDR;
                        end
                    end
                end
            end

            ST_SEND_HDR: begin
                if (xfer) begin
                    state_nxt   = ST_SEND_LEN;
                    tx_data_nxt = {4'b0, n_lat};
`ifdef RESULT_FRAME_CHECKSUM_EN
                    chk_nxt     = 8'h00;
`endif
                end
            end

            ST_SEND_LEN: begin
                if (xfer) begin
                    state_nxt   = ST_SEND_DATA;
                    byte_nxt    = 1'b0;
                    tx_data_nxt = word_byte(rd_data, 1'b0);
`ifdef RESULT_FRAME_CHECKSUM_EN
                    chk_nxt     = chk_q ^ tx_data_q;
`endif
                end
            end

            ST_SEND_DATA: begin
                if (xfer) begin
`ifdef RESULT_FRAME_CHECKSUM_EN
                    chk_nxt = chk_q ^ tx_data_q;
`endif
                    if (byte_idx != LAST_BYTE) begin
                        byte_nxt    = byte_idx + 1'b1;
                        tx_data_nxt = word_byte(rd_data, byte_idx + 1'b1);
                    end else begin
                        // Word fully sent: release it and stage the next one.
                        fifo_pop = !fifo_empty;
                        byte_nxt = 1'b0;
                        if (fifo_count == CW'(1)) begin
`ifdef RESULT_FRAME_CHECKSUM_EN
                            state_nxt   = ST_SEND_CHK;
                            tx_data_nxt = chk_q ^ tx_data_q;
`else
                            state_nxt   = ST_SEND_END;
                            tx_data_nxt = FRAME_END;
`endif
                        end else begin
                            tx_data_nxt = word_byte(rd_data_nxt, 1'b0);
                        end
                    end
                end
            end

`ifdef RESULT_FRAME_CHECKSUM_EN
            ST_SEND_CHK: begin
                if (xfer) begin
                    state_nxt   = ST_SEND_END;
                    tx_data_nxt = FRAME_END;
                end
            end
`endif

            ST_SEND_END: begin
                if (xfer) begin
                    state_nxt    = ST_IDLE;
                    tx_valid_nxt = 1'b0;
                    tx_data_nxt  = 8'h00;
                    done_nxt     = 1'b1;
                end
            end

            default: begin
                state_nxt    = ST_IDLE;
                tx_valid_nxt = 1'b0;
                tx_data_nxt  = 8'h00;
            end
        endcase

        // Results arriving while a frame is on the wire are lost.
        if (push_result && (state != ST_IDLE) && (state != ST_COLLECT)) begin
            ov_set = 1'b1;
        end
    end

    // State and registered outputs; clr outranks everything but reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            n_lat      <= 4'd0;
            byte_idx   <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            status_q   <= '0;
        end else if (clr) begin
            state      <= ST_IDLE;
            n_lat      <= 4'd0;
            byte_idx   <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            status_q   <= '0;
        end else begin
            state             <= state_nxt;
            n_lat             <= n_nxt;
            byte_idx          <= byte_nxt;
            tx_data_q         <= tx_data_nxt;
            tx_valid_q        <= tx_valid_nxt;
            status_q.busy     <= (state_nxt != ST_IDLE);
            status_q.done     <= done_nxt;
            status_q.overflow <= status_q.overflow | ov_set;
        end
    end

`ifdef RESULT_FRAME_CHECKSUM_EN
    // Running XOR of LEN and data bytes as they transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_q <= 8'h00;
        end else if (clr) begin
            chk_q <= 8'h00;
        end else begin
            chk_q <= chk_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_result_frame_sender.sv
// Directed bench for result_frame_sender (DATA_W=16, DEPTH=8).
// Expected frames are built from the pushed words; the checksum byte is
// added when RESULT_FRAME_CHECKSUM_EN is defined.
module tb_result_frame_sender;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        push_result;
    logic [1:0]  processor_number;
    logic [63:0] proc_results;
    logic [3:0]  N;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;
    logic        overflow;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] words [8];

    result_frame_sender #(
        .DATA_W (16),
        .DEPTH  (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .clr              (clr),
        .push_result      (push_result),
        .processor_number (processor_number),
        .proc_results     (proc_results),
        .N                (N),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .busy             (busy),
        .done             (done),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] lane, input logic [15:0] val, input logic [3:0] n);
        for (int j = 0; j < 4; j++) proc_results[j*16 +: 16] = 16'hD000 | 16'(j);
        proc_results[int'(lane)*16 +: 16] = val;
        processor_number = lane;
        N                = n;
        push_result      = 1'b1;
        tick();
        push_result      = 1'b0;
    endtask

    task automatic send_words(input int n);
        for (int i = 0; i < n; i++) push(2'(i % 4), words[i], 4'(n));
    endtask

    task automatic build_frame(input int n);
        exp_q.delete();
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(words[i][15:8]);
            exp_q.push_back(words[i][7:0]);
        end
`ifdef RESULT_FRAME_CHECKSUM_EN
        begin
            logic [7:0] c;
            c = 8'h00;
            for (int k = 1; k < exp_q.size(); k++) c ^= exp_q[k];
            exp_q.push_back(c);
        end
`endif
        exp_q.push_back(8'hEF);
    endtask

    // Drain the frame in exp_q; toggle=1 stalls every other cycle.
    task automatic run_frame(input bit toggle);
        int         idx = 0;
        int         cyc = 0;
        bit         prev_stall = 1'b0;
        bit         rdy;
        logic [7:0] held = 8'h00;
        while (idx < exp_q.size() && cyc < 200) begin
            if (prev_stall) begin
                check("hold_data", 32'(tx_data), 32'(held));
                check("hold_valid", 32'(tx_valid), 32'd1);
            end
            if (!toggle) check("valid", 32'(tx_valid), 32'd1);
            check("no_early_done", 32'(done), 32'd0);
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            tx_ready = rdy;
            if (tx_valid && rdy) begin
                check($sformatf("byte%0d", idx), 32'(tx_data), 32'(exp_q[idx]));
                idx++;
            end
            prev_stall = tx_valid && !rdy;
            held       = tx_data;
            tick();
            cyc++;
        end
        check("frame_len", 32'(idx), 32'(exp_q.size()));
        check("end_valid", 32'(tx_valid), 32'd0);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        tx_ready = 1'b0;
        tick();
        check("done_clear", 32'(done), 32'd0);
    endtask

    initial begin
        reset            = 1'b0;
        clr              = 1'b0;
        push_result      = 1'b0;
        processor_number = 2'd0;
        proc_results     = '0;
        N                = 4'd0;
        tx_ready         = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);

        // Illegal N: push dropped, overflow set, stays idle; clr clears it.
        push(2'd0, 16'h5555, 4'd0);
        check("n0_ovf", 32'(overflow), 32'd1);
        check("n0_busy", 32'(busy), 32'd0);
        push(2'd1, 16'h5555, 4'd9);
        check("n9_busy", 32'(busy), 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_ovf", 32'(overflow), 32'd0);

        // Test 1: N=1.
        words[0] = 16'h1234;
        build_frame(1);
        push(2'd0, 16'h1234, 4'd1);
        run_frame(1'b0);

        // Test 2: N=4 on lanes 0..3.
        words[0] = 16'h0001; words[1] = 16'h0002;
        words[2] = 16'h0003; words[3] = 16'h0004;
        build_frame(4);
        send_words(4);
        run_frame(1'b0);

        // Test 3: N=8 with alternating ready.
        for (int i = 0; i < 8; i++) words[i] = {8'(8'hA0 + i), 8'(8'h50 + i)};
        build_frame(8);
        send_words(8);
        run_frame(1'b1);

        // Test 4: push during SEND_LEN is dropped; frame unaffected.
        words[0] = 16'hBEEF; words[1] = 16'hCAFE;
        build_frame(2);
        send_words(2);
        tx_ready = 1'b1;
        check("t4_hdr", 32'(tx_data), 32'hFE);
        tick();
        tx_ready = 1'b0;
        check("t4_len", 32'(tx_data), 32'h02);
        push(2'd0, 16'h7777, 4'd2);
        check("t4_ovf", 32'(overflow), 32'd1);
        void'(exp_q.pop_front());
        run_frame(1'b0);
        check("t4_ovf_held", 32'(overflow), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t4_ovf_clr", 32'(overflow), 32'd0);

        // Test 5: clr truncates a frame in flight.
        words[0] = 16'h1020; words[1] = 16'h3040;
        words[2] = 16'h5060; words[3] = 16'h7080;
        build_frame(4);
        send_words(4);
        tx_ready = 1'b1;
        repeat (4) tick();
        check("t5_d2", 32'(tx_data), 32'h30);
        check("t5_valid", 32'(tx_valid), 32'd1);
        clr = 1'b1;
        tick();
        clr      = 1'b0;
        tx_ready = 1'b0;
        check("t5_clr_valid", 32'(tx_valid), 32'd0);
        check("t5_clr_busy", 32'(busy), 32'd0);
        words[0] = 16'hABCD;
        build_frame(1);
        push(2'd2, 16'hABCD, 4'd1);
        run_frame(1'b0);

        // Test 6: asynchronous reset mid-SEND_DATA.
        words[0] = 16'h1357; words[1] = 16'h2468;
        build_frame(2);
        send_words(2);
        tx_ready = 1'b1;
        repeat (3) tick();
        check("t6_pre_data", 32'(tx_data), 32'h57);
        check("t6_pre_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_async_valid", 32'(tx_valid), 32'd0);
        check("t6_async_data", 32'(tx_data), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_done", 32'(done), 32'd0);
        tx_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("t6_idle_busy", 32'(busy), 32'd0);
        check("t6_idle_valid", 32'(tx_valid), 32'd0);
        words[0] = 16'h0A0B;
        build_frame(1);
        push(2'd3, 16'h0A0B, 4'd1);
        run_frame(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
